// File: rtl/linebuffer_scanout_if.sv
// Line buffer read port and pixel output bundle for linebuffer_scanout.
// master = scanout block, slave = buffer/timing side.
interface linebuffer_scanout_if;
  logic        line_start;
  logic [8:0]  addr_pix;
  logic [71:0] colour_pix;
  logic        pix_valid;
  logic [8:0]  pix_colour;
  logic        line_done;
  logic        buf_sel;

  modport master (
    input  line_start,
    input  colour_pix,
    output addr_pix,
    output pix_valid,
    output pix_colour,
    output line_done,
    output buf_sel
  );

  modport slave (
    output line_start,
    output colour_pix,
    input  addr_pix,
    input  pix_valid,
    input  pix_colour,
    input  line_done,
    input  buf_sel
  );
endinterface

// File: rtl/linebuffer_scanout.sv
// Scans one line of packed 9-bit pixels out of a ping-pong 512x72
// line buffer with a registered read port, one pixel per pixel clock.
module linebuffer_scanout #(
  parameter int H_ACTIVE = 640
) (
  input logic clk_pix,
  input logic rst_pix,
  linebuffer_scanout_if.master lb
);

  localparam int W = H_ACTIVE / 8;
  localparam logic [7:0] LAST = 8'(W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [71:0] word_q;
  logic [2:0]  lane;
  logic [7:0]  word_idx;
  logic [8:0]  addr;
  logic        buf_sel;
  logic        line_done;
  logic        primed;
  logic        pref;
  logic        last_px;
  logic        pix_valid;
  logic [8:0]  pix_colour;

  // Final lane of a word with nothing prefetched behind it.
  assign last_px = (state == ACTIVE) && (lane == 3'd7) && !pref;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (lb.line_start) state_n = FETCH;
      end
      FETCH: begin
        if (lb.line_start) state_n = FETCH;
        else if (primed)   state_n = ACTIVE;
      end
      ACTIVE: begin
        if (lb.line_start) state_n = FETCH;
        else if (last_px)  state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    pix_valid  = 1'b0;
    pix_colour = 9'd0;
    if (state == ACTIVE) begin
      pix_valid  = 1'b1;
      pix_colour = word_q[9*lane +: 9];
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      word_q    <= 72'd0;
      lane      <= 3'd0;
      word_idx  <= 8'd0;
      addr      <= 9'd0;
      buf_sel   <= 1'b0;
      line_done <= 1'b0;
      primed    <= 1'b0;
      pref      <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (state == FETCH) begin
        primed <= 1'b1;
        // Second fetch cycle: the buffer now presents word 0.
        if (primed) begin
          word_q <= lb.colour_pix;
          lane   <= 3'd0;
        end
      end
      if (state == ACTIVE) begin
        lane <= lane + 3'd1;
        if (lane == 3'd5 && word_idx < LAST) begin
          addr     <= {buf_sel, word_idx + 8'd1};
          word_idx <= word_idx + 8'd1;
          pref     <= 1'b1;
        end
        if (lane == 3'd7) begin
          if (pref) begin
            word_q <= lb.colour_pix;
            pref   <= 1'b0;
          end else begin
            line_done <= 1'b1;
            buf_sel   <= ~buf_sel;
          end
        end
      end
      // A restart lands on the half selected after any completion.
      if (lb.line_start) begin
        addr     <= {last_px ? ~buf_sel : buf_sel, 8'd0};
        word_idx <= 8'd0;
        primed   <= 1'b0;
        pref     <= 1'b0;
      end
    end
  end

  assign lb.addr_pix   = addr;
  assign lb.buf_sel    = buf_sel;
  assign lb.line_done  = line_done;
  assign lb.pix_valid  = pix_valid;
  assign lb.pix_colour = pix_colour;

endmodule

// File: tb/tb_linebuffer_scanout.sv
// Bench for linebuffer_scanout: H_ACTIVE=16 scenarios plus a 640-wide line,
// each against a memory-indexed pixel model.
module tb_linebuffer_scanout;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_sel = 1'b0;

  logic [71:0] mem16  [512];
  logic [71:0] mem640 [512];

  linebuffer_scanout_if if16 ();
  linebuffer_scanout_if if640 ();

  linebuffer_scanout #(.H_ACTIVE(16)) dut16 (
    .clk_pix(clk),
    .rst_pix(rst),
    .lb(if16)
  );

  linebuffer_scanout #(.H_ACTIVE(640)) dut640 (
    .clk_pix(clk),
    .rst_pix(rst),
    .lb(if640)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if16.colour_pix  <= mem16[if16.addr_pix];
    if640.colour_pix <= mem640[if640.addr_pix];
  end

  function automatic logic [8:0] px16(input logic s, input int n);
    logic [71:0] w;
    w = mem16[{s, 8'(n / 8)}];
    return w[9*(n%8) +: 9];
  endfunction

  function automatic logic [8:0] px640(input int n);
    logic [71:0] w;
    w = mem640[9'(n / 8)];
    return w[9*(n%8) +: 9];
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if16.pix_valid, if16.pix_colour, if16.line_done, if16.buf_sel,
         if16.addr_pix} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset16 got v=%b c=%h d=%b s=%b a=%h want all 0",
               if16.pix_valid, if16.pix_colour, if16.line_done,
               if16.buf_sel, if16.addr_pix);
    end
    n_cmp++;
    if ({if640.pix_valid, if640.pix_colour, if640.line_done,
         if640.buf_sel, if640.addr_pix} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset640 got nonzero outputs a=%h", if640.addr_pix);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({if16.pix_valid, if16.line_done, if16.buf_sel} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_after_reset k=%0d got v=%b d=%b s=%b want 000",
                 k, if16.pix_valid, if16.line_done, if16.buf_sel);
      end
    end
  endtask

  task automatic test_basic_line(input string tag);
    logic s, ev, ed, es;
    logic [8:0] ec, ea;
    s = exp_sel;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if16.line_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if16.line_start = 1'b0;
      ev = (k >= 3 && k <= 18);
      ec = ev ? px16(s, k - 3) : 9'd0;
      ed = (k == 19);
      es = (k >= 19) ? ~s : s;
      ea = {s, (k >= 9) ? 8'd1 : 8'd0};
      n_cmp++;
      if ({if16.pix_valid, if16.pix_colour, if16.line_done} !==
          {ev, ec, ed}) begin
        n_bad++;
        $display("FAIL %s k=%0d got v=%b c=%h d=%b want v=%b c=%h d=%b",
                 tag, k, if16.pix_valid, if16.pix_colour, if16.line_done,
                 ev, ec, ed);
      end
      n_cmp++;
      if (if16.addr_pix !== ea) begin
        n_bad++;
        $display("FAIL %s_addr k=%0d got %h want %h",
                 tag, k, if16.addr_pix, ea);
      end
      n_cmp++;
      if (if16.buf_sel !== es) begin
        n_bad++;
        $display("FAIL %s_sel k=%0d got %b want %b", tag, k, if16.buf_sel, es);
      end
    end
    exp_sel = ~s;
  endtask

  task automatic test_collision();
    logic s0, s1, ev, ed, es;
    logic [8:0] ec;
    int j;
    s0 = exp_sel;
    s1 = ~s0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if16.line_start = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if16.line_start = 1'b0;
      j = k - 18;
      if (k <= 18) begin
        ev = (k >= 3);
        ec = ev ? px16(s0, k - 3) : 9'd0;
      end else begin
        ev = (j >= 3 && j <= 18);
        ec = ev ? px16(s1, j - 3) : 9'd0;
      end
      ed = (k == 19) || (k == 37);
      es = (k < 19) ? s0 : ((k < 37) ? s1 : s0);
      n_cmp++;
      if ({if16.pix_valid, if16.pix_colour, if16.line_done,
           if16.buf_sel} !== {ev, ec, ed, es}) begin
        n_bad++;
        $display("FAIL collision k=%0d got v=%b c=%h d=%b s=%b want v=%b c=%h d=%b s=%b",
                 k, if16.pix_valid, if16.pix_colour, if16.line_done,
                 if16.buf_sel, ev, ec, ed, es);
      end
      if (k == 19) begin
        n_cmp++;
        if (if16.addr_pix !== {s1, 8'd0}) begin
          n_bad++;
          $display("FAIL collision_addr got %h want %h",
                   if16.addr_pix, {s1, 8'd0});
        end
      end
      if (k == 18) if16.line_start = 1'b1;
    end
    exp_sel = s0;
  endtask

  task automatic test_abort();
    logic s, ev, ed, es;
    logic [8:0] ec;
    int j;
    s = exp_sel;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if16.line_start = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if16.line_start = 1'b0;
      j = k - 13;
      if (k <= 13) begin
        ev = (k >= 3);
        ec = ev ? px16(s, k - 3) : 9'd0;
      end else begin
        ev = (j >= 3 && j <= 18);
        ec = ev ? px16(s, j - 3) : 9'd0;
      end
      ed = (j == 19);
      es = (j >= 19) ? ~s : s;
      n_cmp++;
      if ({if16.pix_valid, if16.pix_colour, if16.line_done,
           if16.buf_sel} !== {ev, ec, ed, es}) begin
        n_bad++;
        $display("FAIL abort k=%0d got v=%b c=%h d=%b s=%b want v=%b c=%h d=%b s=%b",
                 k, if16.pix_valid, if16.pix_colour, if16.line_done,
                 if16.buf_sel, ev, ec, ed, es);
      end
      if (k == 13) if16.line_start = 1'b1;
    end
    exp_sel = ~s;
  endtask

  task automatic test_reset_midline();
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if16.line_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if16.line_start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({if16.pix_valid, if16.pix_colour, if16.line_done, if16.buf_sel,
         if16.addr_pix} !== 21'd0) begin
      n_bad++;
      $display("FAIL async_reset got v=%b c=%h d=%b s=%b a=%h want all 0",
               if16.pix_valid, if16.pix_colour, if16.line_done,
               if16.buf_sel, if16.addr_pix);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_sel = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if16.pix_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_idle k=%0d got v=%b want 0",
                 k, if16.pix_valid);
      end
    end
    test_basic_line("post_reset");
  endtask

  task automatic test_full_width();
    bit seen [int];
    logic ev, ed;
    logic [8:0] ec;
    int bad_addr;
    bad_addr = 0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    if640.line_start = 1'b1;
    for (int k = 1; k <= 645; k++) begin
      @(negedge clk);
      if640.line_start = 1'b0;
      seen[int'(if640.addr_pix)] = 1'b1;
      ev = (k >= 3 && k <= 642);
      ec = ev ? px640(k - 3) : 9'd0;
      ed = (k == 643);
      n_cmp++;
      if ({if640.pix_valid, if640.pix_colour, if640.line_done} !==
          {ev, ec, ed}) begin
        n_bad++;
        $display("FAIL full k=%0d got v=%b c=%h d=%b want v=%b c=%h d=%b",
                 k, if640.pix_valid, if640.pix_colour, if640.line_done,
                 ev, ec, ed);
      end
    end
    foreach (seen[a]) if (a > 79) bad_addr++;
    n_cmp++;
    if (seen.num() != 80 || bad_addr != 0) begin
      n_bad++;
      $display("FAIL full_addrs got %0d distinct (%0d out of range) want 80 in 0..79",
               seen.num(), bad_addr);
    end
    n_cmp++;
    if (if640.buf_sel !== 1'b1) begin
      n_bad++;
      $display("FAIL full_sel got %b want 1", if640.buf_sel);
    end
  endtask

  initial begin
    if16.line_start  = 1'b0;
    if640.line_start = 1'b0;
    for (int i = 0; i < 512; i++) begin
      mem16[i]  = {8'($urandom), $urandom, $urandom};
      mem640[i] = {8'($urandom), $urandom, $urandom};
    end
    for (int l = 0; l < 8; l++) begin
      mem16[0][9*l +: 9] = 9'(l);
      mem16[1][9*l +: 9] = 9'(256 + l);
    end
    test_reset();
    test_basic_line("basic");
    test_basic_line("second_line");
    test_collision();
    test_abort();
    test_full_width();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
